// File: rtl/if_id_fetch_stage_if.sv
// ----------------------------------------------------------------------------
// if_id_fetch_stage_if
//   Bundles every non-clock signal of the instruction-fetch stage:
//   - hazard control (pc_write, ifid_write)
//   - the EX redirect (branch_taken, branch_target)
//   - the instruction-memory port (imem_addr out, imem_rdata in)
//   - the IF/ID register contents and the debug/perf status.
//
//   Modports:
//     slave  - the fetch stage itself (consumes control + imem data,
//              produces the PC, the IF/ID contents and the status)
//     master - the environment around it (hazard unit, EX, imem, decode)
//
//   Handshake: there is no valid/ready pair on this boundary. if_id_valid
//   qualifies if_id_ins/if_id_pc/if_id_pc4 and is 1 only when they hold a
//   word that was really fetched. Backpressure comes from pc_write and
//   ifid_write, which freeze the PC and IF/ID when low. branch_taken wins
//   over both and forces a redirect plus an IF/ID flush on the same edge.
// ----------------------------------------------------------------------------
interface if_id_fetch_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    // hazard unit / EX controls
    logic             pc_write;
    logic             ifid_write;
    logic             branch_taken;
    logic [XLEN-1:0]  branch_target;

    // instruction memory port (combinational read)
    logic [XLEN-1:0]  imem_addr;
    logic [XLEN-1:0]  imem_rdata;

    // IF/ID pipeline register contents
    logic [31:0]      if_id_ins;
    logic [XLEN-1:0]  if_id_pc;
    logic [XLEN-1:0]  if_id_pc4;
    logic             if_id_valid;

    // debug / performance status
    logic             misaligned;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  pc_write,
        input  ifid_write,
        input  branch_taken,
        input  branch_target,
        input  imem_rdata,
        output imem_addr,
        output if_id_ins,
        output if_id_pc,
        output if_id_pc4,
        output if_id_valid,
        output misaligned,
        output stall_cnt,
        output flush_cnt
    );

    modport master (
        output pc_write,
        output ifid_write,
        output branch_taken,
        output branch_target,
        output imem_rdata,
        input  imem_addr,
        input  if_id_ins,
        input  if_id_pc,
        input  if_id_pc4,
        input  if_id_valid,
        input  misaligned,
        input  stall_cnt,
        input  flush_cnt
    );
endinterface

// File: rtl/if_id_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_id_fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register of the 5-stage
//   RISC-V core. Holds the PC, presents it to the combinational-read
//   instruction memory and latches the returned word into IF/ID together
//   with its PC and PC+4.
//
//   Ports:
//     clk    - rising-edge clock
//     reset  - asynchronous, active-high reset
//     bus    - if_id_fetch_stage_if.slave:
//                pc_write / ifid_write   hazard unit freeze controls
//                branch_taken / _target  redirect + flush request from EX
//                imem_addr / imem_rdata  instruction memory port
//                if_id_ins/_pc/_pc4/_valid  IF/ID register contents
//                misaligned              sticky misaligned-target flag
//                stall_cnt / flush_cnt   saturating perf counters
//
//   Update priority on each edge:
//     PC    : redirect > advance (pc_write) > hold
//     IF/ID : flush (branch_taken) > load (ifid_write) > hold
//   pc_write and ifid_write gate only their own registers; disagreement
//   between them is tolerated silently.
// ----------------------------------------------------------------------------
module if_id_fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INS  = 32'h0000_0013,
    parameter int              CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    if_id_fetch_stage_if.slave bus
);

    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  pc_q,          pc_d;
    logic [31:0]      if_id_ins_q,   if_id_ins_d;
    logic [XLEN-1:0]  if_id_pc_q,    if_id_pc_d;
    logic [XLEN-1:0]  if_id_pc4_q,   if_id_pc4_d;
    logic             if_id_valid_q, if_id_valid_d;
    logic             misaligned_q,  misaligned_d;
    logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,   flush_cnt_d;

    // Sequential PC + 4, wrapping modulo 2^XLEN; shared by the PC advance
    // and the if_id_pc4 capture.
    logic [XLEN-1:0]  pc_plus4;
    // Redirect address with the low two bits cleared so the PC always
    // stays word aligned, even for a bad target.
    logic [XLEN-1:0]  redirect_pc;
    logic             target_misaligned;
    // A stall cycle is one where the PC is frozen by the hazard unit; a
    // redirect moves the PC, so it never counts as a stall.
    logic             stall_event;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_plus4          = pc_q + PC_STEP;
        redirect_pc       = {bus.branch_target[XLEN-1:2], 2'b00};
        target_misaligned = (bus.branch_target[1:0] != 2'b00);
        stall_event       = !bus.pc_write && !bus.branch_taken;
    end

    // PC register input
    always_comb begin
        pc_d = pc_q;
        if (bus.branch_taken) begin
            pc_d = redirect_pc;
        end else if (bus.pc_write) begin
            pc_d = pc_plus4;
        end
    end

    // IF/ID register input. A stall holds every field; the bubble for a
    // load-use stall is inserted downstream in ID/EX, not here.
    always_comb begin
        if_id_ins_d   = if_id_ins_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        if (bus.branch_taken) begin
            if_id_ins_d   = NOP_INS;
            if_id_pc_d    = '0;
            if_id_pc4_d   = '0;
            if_id_valid_d = 1'b0;
        end else if (bus.ifid_write) begin
            if_id_ins_d   = bus.imem_rdata[31:0];
            if_id_pc_d    = pc_q;
            if_id_pc4_d   = pc_plus4;
            if_id_valid_d = 1'b1;
        end
    end

    // Sticky misaligned flag and saturating perf counters
    always_comb begin
        misaligned_d = misaligned_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bus.branch_taken && target_misaligned) begin
            misaligned_d = 1'b1;
        end
        if (stall_event && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (bus.branch_taken && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            if_id_ins_q   <= NOP_INS;
            if_id_pc_q    <= '0;
            if_id_pc4_q   <= '0;
            if_id_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_ins_q   <= if_id_ins_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
            misaligned_q  <= misaligned_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.imem_addr   = pc_q;
        bus.if_id_ins   = if_id_ins_q;
        bus.if_id_pc    = if_id_pc_q;
        bus.if_id_pc4   = if_id_pc4_q;
        bus.if_id_valid = if_id_valid_q;
        bus.misaligned  = misaligned_q;
        bus.stall_cnt   = stall_cnt_q;
        bus.flush_cnt   = flush_cnt_q;
    end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_id_fetch_stage
//   Directed bench for if_id_fetch_stage: sequential fetch, stall, redirect
//   while frozen, misaligned redirect, PC wrap, mismatched write enables,
//   asynchronous reset mid-cycle and stall-counter saturation.
//   Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after
//   the edge that should have produced them.
// ----------------------------------------------------------------------------
module tb_if_id_fetch_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    if_id_fetch_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    if_id_fetch_stage #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0000_0000),
        .NOP_INS  (32'h0000_0013),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory model: three program words, everything else
    // returns the word address with the low bits set to 2'b11.
    always_comb begin
        case (bus.imem_addr)
            32'h0000_0000: bus.imem_rdata = 32'h0050_0093;
            32'h0000_0004: bus.imem_rdata = 32'h0010_0113;
            32'h0000_0008: bus.imem_rdata = 32'h0020_81B3;
            default:       bus.imem_rdata = {bus.imem_addr[31:2], 2'b11};
        endcase
    end

    // ---------------- scoreboard ----------------
    int chk_cnt;
    int pass_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic pcw, input logic ifw, input logic br, input logic [31:0] tgt);
        bus.pc_write      = pcw;
        bus.ifid_write    = ifw;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
    endtask

    // advance one clock edge and settle just past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                              input logic [31:0] pc4, input logic vld);
        check({tag, ".ins"},   bus.if_id_ins,   ins);
        check({tag, ".pc"},    bus.if_id_pc,    pc);
        check({tag, ".pc4"},   bus.if_id_pc4,   pc4);
        check({tag, ".valid"}, 32'(bus.if_id_valid), 32'(vld));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".pc"},   bus.imem_addr, 32'h0);
        check_ifid(tag, 32'h0000_0013, 32'h0, 32'h0, 1'b0);
        check({tag, ".mis"},  32'(bus.misaligned), 32'h0);
        check({tag, ".stall"}, 32'(bus.stall_cnt), 32'h0);
        check({tag, ".flush"}, 32'(bus.flush_cnt), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        reset    = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0);

        // sequential fetch: PC 0 -> 4 -> 8, IF/ID one cycle behind
        step();
        check("seq1.pc", bus.imem_addr, 32'h4);
        check_ifid("seq1", 32'h0050_0093, 32'h0, 32'h4, 1'b1);
        step();
        check("seq2.pc", bus.imem_addr, 32'h8);
        check_ifid("seq2", 32'h0010_0113, 32'h4, 32'h8, 1'b1);

        // two stall cycles at pc=8
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        check("stall.pc", bus.imem_addr, 32'h8);
        check_ifid("stall", 32'h0010_0113, 32'h4, 32'h8, 1'b1);
        check("stall.cnt", 32'(bus.stall_cnt), 32'd2);

        // resume: word at 8 enters IF/ID
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check("resume.pc", bus.imem_addr, 32'hC);
        check_ifid("resume", 32'h0020_81B3, 32'h8, 32'hC, 1'b1);

        // redirect while hazard unit freezes the stage
        drive(1'b0, 1'b0, 1'b1, 32'h40);
        step();
        check("br.pc", bus.imem_addr, 32'h40);
        check_ifid("br", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
        check("br.flush", 32'(bus.flush_cnt), 32'd1);
        check("br.stall", 32'(bus.stall_cnt), 32'd2);
        check("br.mis", 32'(bus.misaligned), 32'h0);

        // misaligned redirect: PC aligned down, sticky flag set
        drive(1'b1, 1'b1, 1'b1, 32'h42);
        step();
        check("mis.pc", bus.imem_addr, 32'h40);
        check("mis.flag", 32'(bus.misaligned), 32'h1);
        check("mis.flush", 32'(bus.flush_cnt), 32'd2);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        step();
        check("mis2.pc", bus.imem_addr, 32'h48);
        check_ifid("mis2", 32'h0000_0047, 32'h44, 32'h48, 1'b1);
        check("mis2.flag", 32'(bus.misaligned), 32'h1);

        // wrap: redirect to last word, then advance
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step();
        check("wrap0.pc", bus.imem_addr, 32'hFFFF_FFFC);
        check("wrap0.flush", 32'(bus.flush_cnt), 32'd3);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check("wrap1.pc", bus.imem_addr, 32'h0);
        check_ifid("wrap1", 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 1'b1);

        // mismatched enables: IF/ID loads, PC holds and counts a stall
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        check("split.pc", bus.imem_addr, 32'h0);
        check_ifid("split", 32'h0050_0093, 32'h0, 32'h4, 1'b1);
        check("split.stall", 32'(bus.stall_cnt), 32'd3);

        // opposite mismatch: PC advances, IF/ID holds
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check("split2.pc", bus.imem_addr, 32'h4);
        check_ifid("split2", 32'h0050_0093, 32'h0, 32'h4, 1'b1);
        check("split2.stall", 32'(bus.stall_cnt), 32'd3);

        // asynchronous reset in mid-cycle, seen before the next edge
        drive(1'b1, 1'b1, 1'b1, 32'h80);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("arst");
        step();
        reset = 1'b0;

        // stall counter saturation: 65535 stalls reach max, one more holds
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (65535) @(posedge clk);
        #1;
        check("sat.cnt", 32'(bus.stall_cnt), 32'h0000_FFFF);
        step();
        check("sat2.cnt", 32'(bus.stall_cnt), 32'h0000_FFFF);
        check("sat2.pc", bus.imem_addr, 32'h0);

        // first fetch after reset comes from RESET_PC
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check("post.pc", bus.imem_addr, 32'h4);
        check_ifid("post", 32'h0050_0093, 32'h0, 32'h4, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // watchdog: the stimulus above runs about 65.6k cycles
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
